// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage constants and state encoding
//
// Purpose: state encodings (FS_IDLE, FS_FETCH, FS_HOLD, FS_SQUASH), the
//          default reset PC and the instruction width used by fetch_unit
//          and fetch_hold_buf.
// Ports:   none (package)
package fetch_unit_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_FETCH  = 2'd1,
        FS_HOLD   = 2'd2,
        FS_SQUASH = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry {valid, pc, inst} stall hold buffer
//
// Purpose: parks a fetched instruction while IF/ID is stalled.
// Ports:
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset
//   load_i   in   capture pc_i/inst_i and mark valid
//   drain_i  in   entry consumed, mark empty
//   clear_i  in   entry discarded (redirect), mark empty
//   pc_i     in   PC of instruction to capture
//   inst_i   in   instruction word to capture
//   valid_o  out  entry holds an instruction
//   pc_o     out  stored PC
//   inst_o   out  stored instruction word
module fetch_hold_buf
    import fetch_unit_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic              clear_i,
    input  logic [31:0]       pc_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              valid_o,
    output logic [31:0]       pc_o,
    output logic [INST_W-1:0] inst_o
);

    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        // Emptying wins; load and drain/clear never coincide in the caller.
        if (drain_i || clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            inst_d  = inst_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, imem port and IF/ID register
//
// Purpose: owns the PC, issues req/ack instruction fetches, parks a fetched
//          word in a hold buffer across stalls, squashes wrong-path fetches
//          on ID/EX redirects and drives the IF/ID register.
// Optional: FETCH_PERF_EN adds fetchCount/squashCount performance counters.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   pcNext                     next PC from branch control
//   id_branchPermit            jump redirect from ID
//   ex_branchPermit            branch redirect from EX
//   stall                      IF/ID must hold
//   pc                         current fetch PC
//   imemReq/imemAddr           fetch request and address
//   imemAck/imemData           fetch completion and instruction word
//   if_valid/if_pc/if_inst     IF/ID register
//   fetchCount/squashCount     (FETCH_PERF_EN) accepted / discarded acks
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pcNext,
    input  logic              id_branchPermit,
    input  logic              ex_branchPermit,
    input  logic              stall,
    output logic [31:0]       pc,
    output logic              imemReq,
    output logic [31:0]       imemAddr,
    input  logic              imemAck,
    input  logic [INST_W-1:0] imemData,
    output logic              if_valid,
    output logic [31:0]       if_pc,
`ifdef FETCH_PERF_EN
    output logic [INST_W-1:0] if_inst,
    output logic [31:0]       fetchCount,
    output logic [31:0]       squashCount
`else
    output logic [INST_W-1:0] if_inst
`endif
);

    fetch_state_e      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       redir_dst_q, redir_dst_d;
    logic              if_valid_q, if_valid_d;
    logic [31:0]       if_pc_q, if_pc_d;
    logic [INST_W-1:0] if_inst_q, if_inst_d;

    logic              redirect;
    logic              hb_load, hb_drain, hb_clear;
    logic              hb_valid;
    logic [31:0]       hb_pc;
    logic [INST_W-1:0] hb_inst;

    assign redirect = id_branchPermit | ex_branchPermit;

    fetch_hold_buf u_hold_buf (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (hb_load),
        .drain_i (hb_drain),
        .clear_i (hb_clear),
        .pc_i    (pc_q),
        .inst_i  (imemData),
        .valid_o (hb_valid),
        .pc_o    (hb_pc),
        .inst_o  (hb_inst)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_dst_d = redir_dst_q;
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;
        hb_load     = 1'b0;
        hb_drain    = 1'b0;
        hb_clear    = 1'b0;
        case (state_q)
            FS_IDLE: begin
                state_d = FS_FETCH;
            end
            FS_FETCH: begin
                if (imemAck) begin
                    pc_d = pcNext;
                    if (redirect) begin
                        if_valid_d = 1'b0;
                    end else if (!stall) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_inst_d  = imemData;
                    end else begin
                        hb_load = 1'b1;
                        state_d = FS_HOLD;
                    end
                end else if (redirect) begin
                    // The request must stay stable until acked, so the
                    // target is parked and the pending fetch is squashed.
                    redir_dst_d = pcNext;
                    if_valid_d  = 1'b0;
                    state_d     = FS_SQUASH;
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                end
            end
            FS_HOLD: begin
                if (redirect) begin
                    hb_clear   = 1'b1;
                    pc_d       = pcNext;
                    if_valid_d = 1'b0;
                    state_d    = FS_FETCH;
                end else if (!stall) begin
                    hb_drain   = 1'b1;
                    if_valid_d = hb_valid;
                    if_pc_d    = hb_pc;
                    if_inst_d  = hb_inst;
                    state_d    = FS_FETCH;
                end
            end
            FS_SQUASH: begin
                if_valid_d = 1'b0;
                if (redirect) begin
                    redir_dst_d = pcNext;
                end
                if (imemAck) begin
                    // A redirect arriving with the ack is the newest target.
                    pc_d    = redirect ? pcNext : redir_dst_q;
                    state_d = FS_FETCH;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FS_IDLE;
            pc_q        <= RESET_PC;
            redir_dst_q <= 32'h0;
            if_valid_q  <= 1'b0;
            if_pc_q     <= 32'h0;
            if_inst_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redir_dst_q <= redir_dst_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
        end
    end

    // imemReq depends on state only; imemAddr is the PC register, which
    // never moves while a request is outstanding.
    assign imemReq  = (state_q == FS_FETCH) || (state_q == FS_SQUASH);
    assign imemAddr = pc_q;
    assign pc       = pc_q;
    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, squash_cnt_q;
    logic        fetch_evt, squash_evt;

    assign fetch_evt  = (state_q == FS_FETCH) && imemAck && !redirect;
    assign squash_evt = imemAck && (((state_q == FS_FETCH) && redirect) ||
                                    (state_q == FS_SQUASH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= 32'h0;
            squash_cnt_q <= 32'h0;
        end else begin
            if (fetch_evt) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (squash_evt) begin
                squash_cnt_q <= squash_cnt_q + 32'd1;
            end
        end
    end

    assign fetchCount  = fetch_cnt_q;
    assign squashCount = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pcNext = 32'h0;
    logic        id_branchPermit = 1'b0;
    logic        ex_branchPermit = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pc;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck = 1'b0;
    logic [31:0] imemData = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
`ifdef FETCH_PERF_EN
    logic [31:0] fetchCount;
    logic [31:0] squashCount;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pcNext          (pcNext),
        .id_branchPermit (id_branchPermit),
        .ex_branchPermit (ex_branchPermit),
        .stall           (stall),
        .pc              (pc),
        .imemReq         (imemReq),
        .imemAddr        (imemAddr),
        .imemAck         (imemAck),
        .imemData        (imemData),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
`ifdef FETCH_PERF_EN
        .if_inst         (if_inst),
        .fetchCount      (fetchCount),
        .squashCount     (squashCount)
`else
        .if_inst         (if_inst)
`endif
    );

    // Reference model: what the fetch stage is doing, as plain flags.
    bit          m_started;    // left the post-reset idle cycle
    bit          m_holding;    // a fetched word is parked during a stall
    bit          m_squashing;  // outstanding fetch is known wrong-path
    logic [31:0] m_pc, m_dst, m_ifpc, m_ifinst, m_hpc, m_hinst;
    bit          m_ifv;
    logic [31:0] m_fcnt, m_scnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_started = 0; m_holding = 0; m_squashing = 0;
        m_pc = 32'h0; m_dst = 32'h0; m_ifv = 0; m_ifpc = 32'h0; m_ifinst = 32'h0;
        m_hpc = 32'h0; m_hinst = 32'h0; m_fcnt = 32'h0; m_scnt = 32'h0;
    endtask

    task automatic check_outputs();
        logic exp_req;
        exp_req = m_started && !m_holding;
        chk("pc", pc, m_pc);
        chk("imemReq", {31'h0, imemReq}, {31'h0, exp_req});
        chk("imemAddr", imemAddr, m_pc);
        chk("if_valid", {31'h0, if_valid}, {31'h0, m_ifv});
        if (m_ifv) begin
            chk("if_pc", if_pc, m_ifpc);
            chk("if_inst", if_inst, m_ifinst);
        end
`ifdef FETCH_PERF_EN
        chk("fetchCount", fetchCount, m_fcnt);
        chk("squashCount", squashCount, m_scnt);
`endif
    endtask

    // Drive one cycle of inputs and advance the model over the coming edge.
    task automatic apply(input logic id, input logic ex, input logic st,
                         input logic ak, input logic [31:0] tgt);
        logic        redir;
        logic [31:0] pn;
        redir = id | ex;
        pn = redir ? tgt : m_pc + 32'd4;
        id_branchPermit = id;
        ex_branchPermit = ex;
        stall = st;
        imemAck = ak;
        pcNext = pn;
        imemData = (ak && m_started && !m_holding) ? mem_word(m_pc) : $urandom;
        if (!m_started) begin
            m_started = 1;
        end else if (m_holding) begin
            if (redir) begin
                m_holding = 0; m_pc = pn; m_ifv = 0;
            end else if (!st) begin
                m_holding = 0; m_ifv = 1; m_ifpc = m_hpc; m_ifinst = m_hinst;
            end
        end else if (m_squashing) begin
            m_ifv = 0;
            if (redir) m_dst = pn;
            if (ak) begin
                m_pc = m_dst; m_squashing = 0; m_scnt++;
            end
        end else if (ak) begin
            if (redir) begin
                m_ifv = 0; m_scnt++;
            end else if (!st) begin
                m_ifv = 1; m_ifpc = m_pc; m_ifinst = mem_word(m_pc); m_fcnt++;
            end else begin
                m_holding = 1; m_hpc = m_pc; m_hinst = mem_word(m_pc); m_fcnt++;
            end
            m_pc = pn;
        end else if (redir) begin
            m_dst = pn; m_ifv = 0; m_squashing = 1;
        end else if (!st) begin
            m_ifv = 0;
        end
    endtask

    task automatic cyc(input logic id, input logic ex, input logic st,
                       input logic ak, input logic [31:0] tgt);
        @(negedge clk);
        check_outputs();
        apply(id, ex, st, ak, tgt);
    endtask

    // Assert reset (asynchronously, mid-cycle), check, release; a late ack
    // during the idle cycle that follows must be ignored.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imemAck = 1'b1;
        #1;
        m_reset();
        check_outputs();
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    endtask

    initial begin
        m_reset();
        do_reset();
        // zero-wait stream, then stall across the ack for 0x8
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        // EX redirect on the ack for 0x10
        cyc(0, 1, 0, 1, 32'h100);
        cyc(0, 0, 0, 1, 0);
        // 3 wait states with an ID jump in the first wait cycle
        cyc(1, 0, 0, 0, 32'h40);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        // PC wrap at the top of the address space
        cyc(0, 1, 0, 1, 32'hFFFF_FFF8);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                $urandom & 32'hFFFF_FFFC);
        end
        // reset in the middle of an outstanding request
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        do_reset();
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        check_outputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
